cpu_control_r_type: RTL and testbench



---
 rtl/cpu_pkg.sv | 18 +
 rtl/cpu_control_r_type_alu.sv | 23 ++
 rtl/cpu_control_r_type_dmem.sv | 22 ++
 rtl/cpu_control_r_type_imem.sv | 11 +
 rtl/cpu_control_r_type_regs.sv | 18 +
 rtl/cpu_control_r_type.sv | 78 +++++++
 tb/tb_cpu_control_r_type.sv | 256 +++++++++++++++++++++++++
 7 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, functs, ALU operations and memory depths shared by the single-cycle core
package cpu_pkg;
    localparam int IMEM_BYTES = 256;
    localparam int DMEM_BYTES = 256;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_ZERO} alu_op_e;
endpackage

// File: rtl/cpu_control_r_type_alu.sv
// cpu_control_r_type_alu: 32-bit ALU with zero flag
module cpu_control_r_type_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     op_i,
    output logic [31:0] y_o,
    output logic        zero_o
);
    always_comb begin
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_NOR: y_o = ~(a_i | b_i);
            ALU_SLT: y_o = {31'd0, $signed(a_i) < $signed(b_i)};
            default: y_o = 32'd0;
        endcase
    end
    assign zero_o = (y_o == 32'd0);
endmodule

// File: rtl/cpu_control_r_type_dmem.sv
// cpu_control_r_type_dmem: byte-wide big-endian data memory, async word read, sync word write
module cpu_control_r_type_dmem
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o
);
    logic [7:0] dataMemory [DMEM_BYTES];
    assign rd_o = {dataMemory[addr_i], dataMemory[addr_i + 8'd1],
                   dataMemory[addr_i + 8'd2], dataMemory[addr_i + 8'd3]};
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            dataMemory[addr_i]        <= wd_i[31:24];
            dataMemory[addr_i + 8'd1] <= wd_i[23:16];
            dataMemory[addr_i + 8'd2] <= wd_i[15:8];
            dataMemory[addr_i + 8'd3] <= wd_i[7:0];
        end
    end
endmodule

// File: rtl/cpu_control_r_type_imem.sv
// cpu_control_r_type_imem: byte-wide big-endian instruction ROM, word fetch wraps at 256
module cpu_control_r_type_imem
    import cpu_pkg::*;
(
    input  logic [7:0]  addr_i,
    output logic [31:0] instr_o
);
    logic [7:0] instBank [IMEM_BYTES];
    assign instr_o = {instBank[addr_i], instBank[addr_i + 8'd1],
                      instBank[addr_i + 8'd2], instBank[addr_i + 8'd3]};
endmodule

// File: rtl/cpu_control_r_type_regs.sv
// cpu_control_r_type_regs: 32x32 register bank, $0 hardwired to zero on read
module cpu_control_r_type_regs (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] registerBank [32];
    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : registerBank[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : registerBank[ra2_i];
    always_ff @(posedge clk_i) begin
        if (we_i && wa_i != 5'd0) registerBank[wa_i] <= wd_i;
    end
endmodule

// File: rtl/cpu_control_r_type.sv
// cpu_control_r_type: single-cycle MIPS-subset core, resultado shows the current ALU output
module cpu_control_r_type
    import cpu_pkg::*;
(
    input  logic        clk_CPU,
    input  logic        rst_CPU,
    output logic [31:0] resultado
);
    logic [31:0] pc_q, pc_d, pc4, instr, rd1, rd2, imm_ext, alu_b, alu_y, mem_rd;
    logic [5:0]  op, funct;
    logic [4:0]  wa;
    logic        reg_we, mem_we, mem_to_reg, zero;
    alu_op_e     alu_op;
    assign op      = instr[31:26];
    assign funct   = instr[5:0];
    assign imm_ext = {{16{instr[15]}}, instr[15:0]};
    assign pc4     = pc_q + 32'd4;
    // unrecognised funct decodes to ALU_ZERO, which also suppresses the register write
    always_comb begin
        alu_op     = ALU_ZERO;
        alu_b      = imm_ext;
        wa         = instr[20:16];
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        case (op)
            OP_RTYPE: begin
                alu_b = rd2;
                wa    = instr[15:11];
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ZERO;
                endcase
                reg_we = (alu_op != ALU_ZERO);
            end
            OP_ADDI: begin
                alu_op = ALU_ADD;
                reg_we = 1'b1;
            end
            OP_LW: begin
                alu_op     = ALU_ADD;
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                alu_op = ALU_ADD;
                mem_we = 1'b1;
            end
            OP_BEQ: begin
                alu_op = ALU_SUB;
                alu_b  = rd2;
            end
            default: ;
        endcase
    end
    assign pc_d = (op == OP_J) ? {pc4[31:28], instr[25:0], 2'b00} :
                  (op == OP_BEQ && zero) ? pc4 + (imm_ext << 2) : pc4;
    always_ff @(posedge clk_CPU) begin
        pc_q <= rst_CPU ? 32'd0 : pc_d;
    end
    cpu_control_r_type_imem IM (.addr_i(pc_q[7:0]), .instr_o(instr));
    cpu_control_r_type_regs BR (
        .clk_i(clk_CPU), .we_i(reg_we && !rst_CPU),
        .ra1_i(instr[25:21]), .ra2_i(instr[20:16]), .wa_i(wa),
        .wd_i(mem_to_reg ? mem_rd : alu_y), .rd1_o(rd1), .rd2_o(rd2)
    );
    cpu_control_r_type_alu alu_u (.a_i(rd1), .b_i(alu_b), .op_i(alu_op), .y_o(alu_y), .zero_o(zero));
    cpu_control_r_type_dmem DM (
        .clk_i(clk_CPU), .we_i(mem_we && !rst_CPU),
        .addr_i(alu_y[7:0]), .wd_i(rd2), .rd_o(mem_rd)
    );
    assign resultado = alu_y;
endmodule

// File: tb/tb_cpu_control_r_type.sv
// tb_cpu_control_r_type: directed and random programs checked against an instruction-level model
module tb_cpu_control_r_type;
    logic        clk_CPU = 1'b0;
    logic        rst_CPU = 1'b1;
    logic [31:0] resultado;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    logic [7:0]  im [256];
    logic [7:0]  dm [256];
    logic [31:0] rf [32];
    logic [31:0] mpc;

    cpu_control_r_type dut (.clk_CPU(clk_CPU), .rst_CPU(rst_CPU), .resultado(resultado));

    always #5 clk_CPU = ~clk_CPU;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] rget(logic [4:0] r);
        return (r == 0) ? 32'd0 : rf[r];
    endfunction

    function automatic logic [31:0] fetch();
        logic [7:0] a = mpc[7:0];
        return {im[a], im[a + 8'd1], im[a + 8'd2], im[a + 8'd3]};
    endfunction

    function automatic bit r_valid(logic [5:0] f);
        return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    endfunction

    function automatic logic [31:0] expect_res();
        logic [31:0] i  = fetch();
        logic [31:0] a  = rget(i[25:21]);
        logic [31:0] b  = rget(i[20:16]);
        logic [31:0] se = sext(i[15:0]);
        if (i[31:26] == 6'h00) begin
            case (i[5:0])
                6'h20: return a + b;
                6'h22: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h27: return ~(a | b);
                6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        if (i[31:26] inside {6'h08, 6'h23, 6'h2B}) return a + se;
        if (i[31:26] == 6'h04) return a - b;
        return 32'd0;
    endfunction

    task automatic model_step();
        logic [31:0] i   = fetch();
        logic [31:0] r   = expect_res();
        logic [31:0] npc = mpc + 32'd4;
        logic [7:0]  ea  = r[7:0];
        logic [31:0] ld  = {dm[ea], dm[ea + 8'd1], dm[ea + 8'd2], dm[ea + 8'd3]};
        logic [31:0] st  = rget(i[20:16]);
        case (i[31:26])
            6'h00: if (r_valid(i[5:0]) && i[15:11] != 0) rf[i[15:11]] = r;
            6'h08: if (i[20:16] != 0) rf[i[20:16]] = r;
            6'h23: if (i[20:16] != 0) rf[i[20:16]] = ld;
            6'h2B: begin
                dm[ea] = st[31:24]; dm[ea + 8'd1] = st[23:16];
                dm[ea + 8'd2] = st[15:8]; dm[ea + 8'd3] = st[7:0];
            end
            6'h04: if (r == 0) npc = npc + (sext(i[15:0]) << 2);
            6'h02: npc = {npc[31:28], i[25:0], 2'b00};
            default: ;
        endcase
        mpc = npc;
    endtask

    always @(posedge clk_CPU) begin
        if (rst_CPU) mpc = 32'd0;
        else model_step();
    end

    always @(posedge clk_CPU) begin
        #2;
        if (chk_en) begin
            chk("resultado", resultado, expect_res());
            chk("pc", dut.pc_q, mpc);
        end
    end

    function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] j_ins(int word);
        return {6'h02, 26'(word)};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        int k  = $urandom_range(0, 11);
        int rs = $urandom_range(0, 7);
        int rt = $urandom_range(0, 7);
        int rd = $urandom_range(0, 7);
        logic [15:0] imm = $urandom_range(0, 1) ? 16'($urandom_range(0, 40)) : 16'hFFFF - 16'($urandom_range(0, 40));
        if (k < 6) return r_ins(rs, rt, rd, fns[k]);
        case (k)
            6: return i_ins(6'h08, rs, rt, imm);
            7: return i_ins(6'h23, rs, rt, imm);
            8: return i_ins(6'h2B, rs, rt, imm);
            9: return i_ins(6'h04, rs, rt, imm);
            10: return j_ins($urandom_range(0, 63));
            default: return $urandom_range(0, 1) ? i_ins(6'h3F, rs, rt, imm) : r_ins(rs, rt, rd, 6'h21);
        endcase
    endfunction

    task automatic set_reg(int r, logic [31:0] v);
        rf[r] = v;
        dut.BR.registerBank[r] = v;
    endtask

    task automatic set_dbyte(int a, logic [7:0] v);
        dm[a % 256] = v;
        dut.DM.dataMemory[a % 256] = v;
    endtask

    task automatic set_word(int a, logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            im[(a + k) % 256] = v[31 - 8 * k -: 8];
            dut.IM.instBank[(a + k) % 256] = v[31 - 8 * k -: 8];
        end
    endtask

    task automatic begin_prog();
        @(negedge clk_CPU);
        rst_CPU = 1'b1;
        for (int a = 0; a < 256; a += 4) set_word(a, 32'hFFFF_FFFF);
    endtask

    task automatic start();
        @(negedge clk_CPU);
        rst_CPU = 1'b0;
    endtask

    function automatic logic [31:0] dut_dword(int a);
        return {dut.DM.dataMemory[a], dut.DM.dataMemory[a + 1], dut.DM.dataMemory[a + 2], dut.DM.dataMemory[a + 3]};
    endfunction

    initial begin
        for (int a = 0; a < 256; a++) begin
            set_dbyte(a, 8'h00);
            set_word(a & ~3, 32'hFFFF_FFFF);
        end
        for (int r = 0; r < 32; r++) set_reg(r, 32'd0);
        chk_en = 1'b1;
        // R-type group followed by an unknown opcode
        begin_prog();
        set_reg(1, 5); set_reg(2, 3);
        set_word(0, r_ins(1, 2, 3, 6'h20));
        set_word(4, r_ins(1, 2, 4, 6'h22));
        set_word(8, r_ins(2, 1, 5, 6'h2A));
        set_word(12, r_ins(0, 0, 6, 6'h27));
        start();
        chk("add_res", resultado, 32'd8);
        @(negedge clk_CPU); chk("sub_res", resultado, 32'd2);
        @(negedge clk_CPU); chk("slt_res", resultado, 32'd1);
        @(negedge clk_CPU); chk("nor_res", resultado, 32'hFFFF_FFFF);
        @(negedge clk_CPU); chk("unk_res", resultado, 32'd0);
        chk("r3", dut.BR.registerBank[3], 32'd8);
        chk("r4", dut.BR.registerBank[4], 32'd2);
        chk("r5", dut.BR.registerBank[5], 32'd1);
        chk("r6", dut.BR.registerBank[6], 32'hFFFF_FFFF);
        @(negedge clk_CPU); chk("unk_pc", dut.pc_q, 32'h14);
        // load then store
        begin_prog();
        set_dbyte(0, 8'h00); set_dbyte(1, 8'h00); set_dbyte(2, 8'h00); set_dbyte(3, 8'h2A);
        for (int a = 8; a < 12; a++) set_dbyte(a, 8'h11);
        set_word(0, i_ins(6'h23, 0, 7, 16'd0));
        set_word(4, i_ins(6'h2B, 0, 7, 16'd8));
        start();
        chk("lw_ea", resultado, 32'd0);
        @(negedge clk_CPU); chk("lw_r7", dut.BR.registerBank[7], 32'd42);
        chk("sw_ea", resultado, 32'd8);
        @(negedge clk_CPU); chk("sw_mem", dut_dword(8), 32'h0000_002A);
        // beq taken and not taken
        for (int t = 0; t < 2; t++) begin
            begin_prog();
            set_reg(1, 5); set_reg(8, t == 0 ? 5 : 6);
            set_word(16, i_ins(6'h04, 1, 8, 16'd2));
            start();
            repeat (4) @(negedge clk_CPU);
            chk("beq_res", resultado, t == 0 ? 32'd0 : 32'hFFFF_FFFF);
            @(negedge clk_CPU); chk("beq_pc", dut.pc_q, t == 0 ? 32'h1C : 32'h14);
        end
        // jump loop, then a reset with an addi in flight
        begin_prog();
        set_reg(1, 5); set_reg(11, 0);
        set_word(0, j_ins(8));
        set_word(32, j_ins(4));
        for (int a = 16; a < 28; a += 4) set_word(a, i_ins(6'h08, 11, 11, 16'd1));
        set_word(28, j_ins(4));
        start();
        @(negedge clk_CPU); chk("j0_pc", dut.pc_q, 32'h20);
        @(negedge clk_CPU); chk("j20_pc", dut.pc_q, 32'h10);
        repeat (4) @(negedge clk_CPU);
        chk("loop_pc", dut.pc_q, 32'h10);
        chk("loop_r11", dut.BR.registerBank[11], 32'd3);
        rst_CPU = 1'b1;
        @(negedge clk_CPU);
        chk("rst_pc", dut.pc_q, 32'd0);
        chk("rst_r11", dut.BR.registerBank[11], 32'd3);
        chk("rst_r1", dut.BR.registerBank[1], 32'd5);
        rst_CPU = 1'b0;
        @(negedge clk_CPU); chk("restart_pc", dut.pc_q, 32'h20);
        // $0 write discard and addi sign extension
        begin_prog();
        set_reg(0, 0); set_reg(1, 5); set_reg(2, 3);
        set_word(0, r_ins(1, 2, 0, 6'h20));
        set_word(4, r_ins(0, 0, 10, 6'h25));
        set_word(8, i_ins(6'h08, 0, 9, 16'hFFFF));
        start();
        chk("r0_add_res", resultado, 32'd8);
        @(negedge clk_CPU); chk("r0_kept", dut.BR.registerBank[0], 32'd0);
        chk("r0_read", resultado, 32'd0);
        @(negedge clk_CPU); chk("addi_res", resultado, 32'hFFFF_FFFF);
        @(negedge clk_CPU); chk("addi_r9", dut.BR.registerBank[9], 32'hFFFF_FFFF);
        // random programs with sporadic resets
        begin_prog();
        for (int r = 1; r < 32; r++) set_reg(r, $urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(0, 300)));
        for (int a = 0; a < 256; a++) set_dbyte(a, 8'($urandom));
        for (int a = 0; a < 256; a += 4) set_word(a, rand_ins());
        start();
        repeat (800) begin
            @(negedge clk_CPU);
            rst_CPU = ($urandom_range(0, 39) == 0);
        end
        rst_CPU = 1'b0;
        @(negedge clk_CPU);
        for (int r = 1; r < 32; r++) chk($sformatf("rand_r%0d", r), dut.BR.registerBank[r], rf[r]);
        for (int a = 0; a < 256; a += 4) chk($sformatf("rand_dm%0d", a), dut_dword(a), {dm[a], dm[a + 1], dm[a + 2], dm[a + 3]});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
